// File: rtl/operand_stack_pkg.sv
// Shared definitions for the operand stack: op encoding, error codes and per-op
// depth requirements / net depth change.
package stack_pkg;

  typedef enum logic [2:0] {
    STK_NOP          = 3'b000,
    STK_PUSH         = 3'b001,
    STK_POP1         = 3'b010,
    STK_POP2         = 3'b011,
    STK_REPLACE      = 3'b100,
    STK_POP1_REPLACE = 3'b101,
    STK_DUP          = 3'b110,
    STK_SWAP         = 3'b111
  } stk_op_e;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_OVER  = 2'b10;

  function automatic logic [1:0] op_min_depth(input stk_op_e op);
    case (op)
      STK_POP1, STK_REPLACE, STK_DUP:        op_min_depth = 2'd1;
      STK_POP2, STK_POP1_REPLACE, STK_SWAP:  op_min_depth = 2'd2;
      default:                               op_min_depth = 2'd0;
    endcase
  endfunction

  function automatic logic op_grows(input stk_op_e op);
    op_grows = (op == STK_PUSH) || (op == STK_DUP);
  endfunction

  // Two's-complement net change of depth for a committed op.
  function automatic logic [2:0] op_delta(input stk_op_e op);
    case (op)
      STK_PUSH, STK_DUP:          op_delta = 3'b001;
      STK_POP1, STK_POP1_REPLACE: op_delta = 3'b111;
      STK_POP2:                   op_delta = 3'b110;
      default:                    op_delta = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/operand_stack_if.sv
// Decode/write-back to stack connection: op and write data in, TOS/NOS and status out.
interface operand_stack_if #(
  parameter int unsigned REG_BITS = 32,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned PTR_BITS = $clog2(DEPTH)
);
  logic [2:0]          op;
  logic [REG_BITS-1:0] wr_data;
  logic [REG_BITS-1:0] tos;
  logic [REG_BITS-1:0] nos;
  logic [PTR_BITS:0]   depth;
  logic                empty;
  logic                full;
  logic                err;
  logic [1:0]          err_code;

  modport master (
    output op, wr_data,
    input  tos, nos, depth, empty, full, err, err_code
  );

  modport slave (
    input  op, wr_data,
    output tos, nos, depth, empty, full, err, err_code
  );
endinterface

// File: rtl/operand_stack_regfile.sv
// DEPTH x REG_BITS entry array: two combinational read ports, two write ports
// committing on the same edge (port B serves only SWAP).
module stack_regfile #(
  parameter int unsigned REG_BITS = 32,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned PTR_BITS = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic [PTR_BITS-1:0] ra_idx,
  output logic [REG_BITS-1:0] ra_data,
  input  logic [PTR_BITS-1:0] rb_idx,
  output logic [REG_BITS-1:0] rb_data,
  input  logic                wa_en,
  input  logic [PTR_BITS-1:0] wa_idx,
  input  logic [REG_BITS-1:0] wa_data,
  input  logic                wb_en,
  input  logic [PTR_BITS-1:0] wb_idx,
  input  logic [REG_BITS-1:0] wb_data
);

  logic [REG_BITS-1:0] mem_q [DEPTH];
  logic [REG_BITS-1:0] mem_d [DEPTH];

  assign ra_data = mem_q[ra_idx];
  assign rb_data = mem_q[rb_idx];

  always_comb begin
    mem_d = mem_q;
    if (wa_en) mem_d[wa_idx] = wa_data;
    if (wb_en) mem_d[wb_idx] = wb_data;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/operand_stack.sv
// Operand stack top: depth counter, op decode and sticky error capture.
// Bounds checking and err/err_code exist only when OPERAND_STACK_BOUNDS_CHECK_EN is defined.
module operand_stack
  import stack_pkg::*;
#(
  parameter int unsigned REG_BITS = 32,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned PTR_BITS = $clog2(DEPTH)
) (
  input logic            clk,
  input logic            reset,
  operand_stack_if.slave bus
);

  localparam logic [PTR_BITS:0] DEPTH_CNT = (PTR_BITS+1)'(DEPTH);

  stk_op_e             op;
  logic [PTR_BITS:0]   depth_q, depth_d;
  logic [PTR_BITS-1:0] idx_top, idx_m1, idx_m2;
  logic [REG_BITS-1:0] rd_a, rd_b, tos_v, nos_v;
  logic                wa_en, wb_en;
  logic [PTR_BITS-1:0] wa_idx, wb_idx;
  logic [REG_BITS-1:0] wa_data, wb_data;
  logic [2:0]          delta;
  logic                legal;

  assign op      = stk_op_e'(bus.op);
  assign delta   = op_delta(op);
  assign idx_top = depth_q[PTR_BITS-1:0];
  assign idx_m1  = idx_top - PTR_BITS'(1);
  assign idx_m2  = idx_top - PTR_BITS'(2);

  stack_regfile #(
    .REG_BITS (REG_BITS),
    .DEPTH    (DEPTH),
    .PTR_BITS (PTR_BITS)
  ) u_regfile (
    .clk     (clk),
    .ra_idx  (idx_m1),
    .ra_data (rd_a),
    .rb_idx  (idx_m2),
    .rb_data (rd_b),
    .wa_en   (wa_en),
    .wa_idx  (wa_idx),
    .wa_data (wa_data),
    .wb_en   (wb_en),
    .wb_idx  (wb_idx),
    .wb_data (wb_data)
  );

`ifdef OPERAND_STACK_BOUNDS_CHECK_EN
  logic       err_q, err_d;
  logic [1:0] err_code_q, err_code_d;
  logic       under, over;

  always_comb begin
    under      = depth_q < {{(PTR_BITS-1){1'b0}}, op_min_depth(op)};
    over       = op_grows(op) && (depth_q == DEPTH_CNT);
    legal      = !(under || over);
    err_d      = err_q;
    err_code_d = err_code_q;
    if (!legal) begin
      err_d = 1'b1;
      if (!err_q) err_code_d = under ? ERR_UNDER : ERR_OVER;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;
`else
  assign legal        = 1'b1;
  assign bus.err      = 1'b0;
  assign bus.err_code = ERR_NONE;
`endif

  // DUP and SWAP source the masked TOS/NOS so stale entries never leak in.
  always_comb begin
    tos_v   = (depth_q != '0) ? rd_a : '0;
    nos_v   = (depth_q > (PTR_BITS+1)'(1)) ? rd_b : '0;
    wa_en   = 1'b0;
    wb_en   = 1'b0;
    wa_idx  = idx_top;
    wa_data = bus.wr_data;
    wb_idx  = idx_m2;
    wb_data = tos_v;
    depth_d = depth_q;
    if (legal && !reset) begin
      depth_d = depth_q + {{(PTR_BITS-2){delta[2]}}, delta};
      case (op)
        STK_PUSH: wa_en = 1'b1;
        STK_REPLACE: begin
          wa_en  = 1'b1;
          wa_idx = idx_m1;
        end
        STK_POP1_REPLACE: begin
          wa_en  = 1'b1;
          wa_idx = idx_m2;
        end
        STK_DUP: begin
          wa_en   = 1'b1;
          wa_data = tos_v;
        end
        STK_SWAP: begin
          wa_en   = 1'b1;
          wa_idx  = idx_m1;
          wa_data = nos_v;
          wb_en   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) depth_q <= '0;
    else       depth_q <= depth_d;
  end

  assign bus.tos   = tos_v;
  assign bus.nos   = nos_v;
  assign bus.depth = depth_q;
  assign bus.empty = (depth_q == '0);
  assign bus.full  = (depth_q == DEPTH_CNT);

endmodule

// File: tb/tb_operand_stack.sv
// Self-checking bench for operand_stack: directed scenarios plus random ops
// compared every cycle against an array-based stack model.
module tb_operand_stack;
  localparam int RW = 16;
  localparam int D  = 8;
  localparam int PB = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  operand_stack_if #(.REG_BITS(RW), .DEPTH(D)) bus ();

  operand_stack #(.REG_BITS(RW), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          chk_en = 1'b0;

  int          m_depth = 0;
  logic [RW-1:0] m_mem [D];
  bit          m_known [D];
  bit          m_err = 1'b0;
  logic [1:0]  m_code = 2'b00;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int ix(input int k);
    return (((m_depth - k) % D) + D) % D;
  endfunction

  function automatic logic [RW-1:0] m_tos();
    return (m_depth >= 1) ? m_mem[ix(1)] : '0;
  endfunction

  function automatic logic [RW-1:0] m_nos();
    return (m_depth >= 2) ? m_mem[ix(2)] : '0;
  endfunction

  function automatic bit tos_known();
    return (m_depth < 1) || m_known[ix(1)];
  endfunction

  function automatic bit nos_known();
    return (m_depth < 2) || m_known[ix(2)];
  endfunction

  task automatic model_step(input logic [2:0] o, input logic [RW-1:0] wd, input bit rst);
    logic [RW-1:0] t, n;
    bit tk, nk;
    int need, dd;
    int wi0, wi1, wi2;
    if (rst) begin
      m_depth = 0;
      m_err   = 1'b0;
      m_code  = 2'b00;
      return;
    end
    t = m_tos(); n = m_nos(); tk = tos_known(); nk = nos_known();
    need = (o == 3'd2 || o == 3'd4 || o == 3'd6) ? 1 :
           (o == 3'd3 || o == 3'd5 || o == 3'd7) ? 2 : 0;
`ifdef OPERAND_STACK_BOUNDS_CHECK_EN
    if (m_depth < need) begin
      if (!m_err) m_code = 2'b01;
      m_err = 1'b1;
      return;
    end
    if ((o == 3'd1 || o == 3'd6) && m_depth == D) begin
      if (!m_err) m_code = 2'b10;
      m_err = 1'b1;
      return;
    end
`else
    if (need < 0) return;
`endif
    wi0 = ix(0); wi1 = ix(1); wi2 = ix(2);
    dd = 0;
    case (o)
      3'd1: begin m_mem[wi0] = wd; m_known[wi0] = 1'b1; dd = 1; end
      3'd2: dd = -1;
      3'd3: dd = -2;
      3'd4: begin m_mem[wi1] = wd; m_known[wi1] = 1'b1; end
      3'd5: begin m_mem[wi2] = wd; m_known[wi2] = 1'b1; dd = -1; end
      3'd6: begin m_mem[wi0] = t; m_known[wi0] = tk; dd = 1; end
      3'd7: begin
        m_mem[wi1] = n; m_known[wi1] = nk;
        m_mem[wi2] = t; m_known[wi2] = tk;
      end
      default: ;
    endcase
    m_depth = (((m_depth + dd) % (2 * D)) + 2 * D) % (2 * D);
  endtask

  // Drive one cycle; returns #1 after the commit edge with the model updated.
  task automatic cycle(input logic [2:0] o, input logic [RW-1:0] wd, input bit rst);
    bus.op      = o;
    bus.wr_data = wd;
    reset       = rst;
    @(posedge clk);
    model_step(o, wd, rst);
    #1;
    chk_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("depth", 32'(bus.depth), 32'(m_depth));
      chk("empty", 32'(bus.empty), 32'(m_depth == 0));
      chk("full", 32'(bus.full), 32'(m_depth == D));
      chk("err", 32'(bus.err), 32'(m_err));
      chk("err_code", 32'(bus.err_code), 32'(m_code));
      if (tos_known()) chk("tos", 32'(bus.tos), 32'(m_tos()));
      if (nos_known()) chk("nos", 32'(bus.nos), 32'(m_nos()));
    end
  end

  initial begin
    bus.op = 3'd0;
    bus.wr_data = '0;
    for (int i = 0; i < D; i++) m_known[i] = 1'b0;

    cycle(3'd0, '0, 1'b1);
    chk("rst_depth", 32'(bus.depth), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_tos", 32'(bus.tos), 0);
    chk("rst_nos", 32'(bus.nos), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_code", 32'(bus.err_code), 0);

    cycle(3'd1, 16'd5, 1'b0);
    cycle(3'd1, 16'd7, 1'b0);
    cycle(3'd5, 16'd12, 1'b0);
    chk("p1r_depth", 32'(bus.depth), 1);
    chk("p1r_tos", 32'(bus.tos), 12);
    chk("p1r_nos", 32'(bus.nos), 0);
    chk("p1r_err", 32'(bus.err), 0);
    chk("p1r_model_tos", 32'(m_tos()), 12);

    cycle(3'd0, '0, 1'b1);
    cycle(3'd1, 16'd1, 1'b0);
    cycle(3'd1, 16'd2, 1'b0);
    cycle(3'd7, 16'hdead, 1'b0);
    cycle(3'd6, 16'hbeef, 1'b0);
    chk("dup_depth", 32'(bus.depth), 3);
    chk("dup_tos", 32'(bus.tos), 1);
    chk("dup_nos", 32'(bus.nos), 1);
    cycle(3'd3, '0, 1'b0);
    chk("pop2_depth", 32'(bus.depth), 1);
    chk("pop2_tos", 32'(bus.tos), 2);
    chk("pop2_model_tos", 32'(m_tos()), 2);

    cycle(3'd0, '0, 1'b1);
    cycle(3'd2, '0, 1'b0);
`ifdef OPERAND_STACK_BOUNDS_CHECK_EN
    chk("under_depth", 32'(bus.depth), 0);
    chk("under_err", 32'(bus.err), 1);
    chk("under_code", 32'(bus.err_code), 1);
    cycle(3'd1, 16'd9, 1'b0);
    chk("after_under_tos", 32'(bus.tos), 9);
    chk("after_under_code", 32'(bus.err_code), 1);
`else
    chk("wrap_depth", 32'(bus.depth), 2 * D - 1);
    chk("wrap_err", 32'(bus.err), 0);
    cycle(3'd1, 16'd9, 1'b0);
    chk("wrap_push_depth", 32'(bus.depth), 0);
    chk("wrap_push_tos", 32'(bus.tos), 0);
`endif

    cycle(3'd0, '0, 1'b1);
    for (int i = 0; i < D; i++) cycle(3'd1, RW'(i), 1'b0);
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_tos", 32'(bus.tos), D - 1);
    cycle(3'd1, 16'd99, 1'b0);
`ifdef OPERAND_STACK_BOUNDS_CHECK_EN
    chk("over_depth", 32'(bus.depth), D);
    chk("over_err", 32'(bus.err), 1);
    chk("over_code", 32'(bus.err_code), 2);
    chk("over_tos", 32'(bus.tos), D - 1);
`else
    chk("over_depth", 32'(bus.depth), D + 1);
    chk("over_full", 32'(bus.full), 0);
    chk("over_tos", 32'(bus.tos), 99);
    chk("over_nos", 32'(bus.nos), D - 1);
`endif

    cycle(3'd1, 16'd3, 1'b0);
    cycle(3'd4, 16'd4, 1'b1);
    chk("rstop_depth", 32'(bus.depth), 0);
    chk("rstop_tos", 32'(bus.tos), 0);
    chk("rstop_err", 32'(bus.err), 0);

    for (int n = 0; n < 400; n++) begin
      logic [2:0] o;
      bit r;
      o = ($urandom_range(0, 9) < 4) ? 3'd1 : 3'($urandom_range(0, 7));
      r = ($urandom_range(0, 59) == 0);
      cycle(o, RW'($urandom), r);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_stack.md
# operand_stack

Hardware operand stack for the single-cycle stack machine. Holds the evaluation stack and presents top-of-stack (TOS) and next-on-stack (NOS) to the ALU, data-memory and branch paths. Decode drives one stack operation per cycle and write-back drives the value to store. All pointer updates and writes commit at the same clock edge. Replaces the ad-hoc pointer updates currently sensitive to control-signal changes.

## Interface
- REG_BITS, 32, data word width (16 or 32)
- DEPTH, 64, number of stack entries; power of two, at least 4
- PTR_BITS, $clog2(DEPTH), entry index width

- clk  in  1  clock; all state changes on posedge
- reset  in  1  synchronous, active-high; clears pointer and flags
- op  in  3  stack operation this cycle (encoding under Operation)
- wr_data  in  REG_BITS  value written by PUSH, REPLACE and POP1_REPLACE
- tos  out  REG_BITS  entry at depth-1; 0 when depth < 1
- nos  out  REG_BITS  entry at depth-2; 0 when depth < 2
- depth  out  PTR_BITS+1  current number of valid entries
- empty  out  1  depth == 0
- full  out  1  depth == DEPTH
- err  out  1  sticky; set by a rejected op
- err_code  out  2  first error cause: 00 none, 01 underflow, 10 overflow

## Operation
- Op encoding:
  - 000 NOP
  - 001 PUSH: mem[depth] = wr_data; depth +1
  - 010 POP1: depth -1
  - 011 POP2: depth -2
  - 100 REPLACE: TOS = wr_data; depth unchanged
  - 101 POP1_REPLACE (binary ALU result): mem[depth-2] = wr_data; depth -1
  - 110 DUP: mem[depth] = TOS; depth +1
  - 111 SWAP: TOS and NOS exchanged; depth unchanged
- Entry requirements:
  - POP1, REPLACE and DUP need depth >= 1.
  - POP2, POP1_REPLACE and SWAP need depth >= 2.
  - PUSH and DUP need depth < DEPTH.
- Rejected op:
  - No write and no depth change.
  - err is set to 1.
  - err_code records the cause only if err was 0 beforehand, so the first cause is kept.
- Once set, err and err_code hold until reset. Subsequent legal ops still execute.
- wr_data is sampled only at the commit edge of ops that use it; otherwise it is ignored.
- Arithmetic: depth is unsigned PTR_BITS+1. Entry index = depth minus k, taken modulo DEPTH, and is only used when guarded by the requirements above.
- Entry contents are not reset. After reset, tos and nos are forced to 0 by the depth masks.

## Timing
- Reset values:
  - depth = 0
  - empty = 1
  - full = 0
  - err = 0
  - err_code = 00
  - tos = 0
  - nos = 0
- reset has priority over op in the same cycle.
- Reset asserted mid-sequence discards the stack in one cycle. Any op present during reset is ignored.
- Reads are combinational from the stored state. tos, nos and depth reflect the cycle-N op from cycle N+1 (zero-cycle read, one-edge update).
- SWAP performs two writes at the same edge. POP1_REPLACE's write and pointer move are atomic.
- Back-to-back ops are legal every cycle. There is no stall or handshake; the caller is responsible for legal sequencing.
- full to PUSH: rejected, overflow. depth stays at DEPTH.
- empty to POP1: rejected, underflow. depth stays 0.

## Configuration
- OPERAND_STACK_BOUNDS_CHECK_EN
- Defined: requirement checks, rejection, err and err_code are active as described above.
- Undefined: no checks.
  - The index wraps modulo DEPTH and depth counts modulo 2·DEPTH.
  - full = (depth == DEPTH) and empty = (depth == 0), evaluated on the wrapped count.
  - tos and nos masking still applies.
  - err and err_code are tied to 0.
  - The implementation saves the comparison logic.

## Structure
- Package stack_pkg:
  - op encoding enum (STK_NOP through STK_SWAP)
  - err_code constants (ERR_NONE, ERR_UNDER, ERR_OVER)
  - per-op minimum-depth and net-delta constants
- Sub-module stack_regfile: DEPTH x REG_BITS register array with two combinational read ports and two synchronous write ports. Write port B is used only by SWAP. Simultaneous writes to different indices are always guaranteed.
- The top level holds the depth counter, op decode and error logic.

## Test plan
- Reset, then PUSH 5, PUSH 7, POP1_REPLACE 12 -> depth 1, tos 12, nos 0, err 0.
- PUSH 1, PUSH 2, SWAP, DUP -> depth 3, tos 1, nos 1, then POP2 -> depth 1, tos 2.
- From reset, POP1 -> depth 0, err 1, err_code 01; then PUSH 9 -> tos 9, err_code still 01.
- PUSH DEPTH times (values 0..DEPTH-1) -> full 1, tos DEPTH-1; one more PUSH -> depth DEPTH, err 1, err_code 10, tos unchanged.
- PUSH 3, REPLACE 4 with reset asserted in the same cycle -> next cycle depth 0, tos 0, err 0.
- Build with macro undefined: POP1 from empty -> depth wraps to 2·DEPTH-1, err 0. With macro defined: same stimulus is rejected.
